// File: rtl/rgb_status_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_status_sequencer
//
// Purpose:
//   Status LED controller for the robot. The raw power switch is debounced.
//   A prioritised state machine tracks dock, power, battery and obstacle
//   conditions. The result drives a steady or blinking pattern on the RGB LED,
//   and the current state is exported for the motor/navigation logic.
//
// Parameters:
//   DEB_CYCLES  consecutive differing samples of power before the debounced
//               value flips (>= 1)
//   BLINK_HALF  blink half-period in clock cycles (>= 1)
//   CNT_W       width of the debounce and blink counters; must hold both
//               DEB_CYCLES-1 and BLINK_HALF-1
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous reset, active high
//   power          in   raw power switch, 1 = on (may bounce)
//   batery_status  in   1 = battery OK, 0 = low
//   allSensores    in   1 = all obstacle sensors blocked
//   charger        in   1 = docked on charger
//   out_r/g/b      out  LED drive, 1 = lit
//   state          out  current state encoding
//                       (0 OFF, 1 RUN, 2 BLOCKED, 3 LOW_BAT, 4 CHARGING)
// -----------------------------------------------------------------------------
module rgb_status_sequencer #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned BLINK_HALF = 25000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power,
    input  logic       batery_status,
    input  logic       allSensores,
    input  logic       charger,
    output logic       out_r,
    output logic       out_g,
    output logic       out_b,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_RUN      = 3'd1,
        ST_BLOCKED  = 3'd2,
        ST_LOW_BAT  = 3'd3,
        ST_CHARGING = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Registers and next-state values
    // -------------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic               pwr_db_q,    pwr_db_d;
    logic [CNT_W-1:0]   deb_cnt_q,   deb_cnt_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    logic               bat_q;

    logic               state_change;

    // -------------------------------------------------------------------------
    // Power debounce: the debounced value flips only after DEB_CYCLES
    // consecutive samples that disagree with it; any agreeing sample restarts
    // the count.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pwr_db_d  = pwr_db_q;
        deb_cnt_d = deb_cnt_q;
        if (power == pwr_db_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            pwr_db_d  = power;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Next state: the same priority list applies from every legal state, so
    // the current state only matters for recovering from illegal encodings.
    // The debounced power used here is the registered value, which puts state
    // one edge behind the debounce flip.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = ST_OFF;
        case (state_q)
            ST_OFF, ST_RUN, ST_BLOCKED, ST_LOW_BAT, ST_CHARGING: begin
                if (charger) begin
                    state_d = ST_CHARGING;
                end else if (!pwr_db_q) begin
                    state_d = ST_OFF;
                end else if (!batery_status) begin
                    state_d = ST_LOW_BAT;
                end else if (allSensores) begin
                    state_d = ST_BLOCKED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // Encodings 5..7 are unreachable; fall back to OFF if one appears.
            default: state_d = ST_OFF;
        endcase
    end

    assign state_change = (state_d != state_q);

    // -------------------------------------------------------------------------
    // Blink generator: restarts lit on every state entry, then toggles every
    // BLINK_HALF cycles. The counter wraps only through the compare.
    // -------------------------------------------------------------------------
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_change) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order; the reset is
    // synchronous, so it sits inside the clocked block rather than in the
    // sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            pwr_db_q    <= 1'b0;
            deb_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            bat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_db_q    <= pwr_db_d;
            deb_cnt_q   <= deb_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            bat_q       <= batery_status;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode: purely from registered values, so the LED pins never see
    // a combinational path from the board inputs. While charging, a full
    // battery shows steady blue; otherwise blue blinks.
    // -------------------------------------------------------------------------
    always_comb begin
        out_r = 1'b0;
        out_g = 1'b0;
        out_b = 1'b0;
        case (state_q)
            ST_RUN:      out_g = 1'b1;
            ST_BLOCKED:  out_r = phase_q;
            ST_LOW_BAT:  out_r = 1'b1;
            ST_CHARGING: out_b = bat_q ? 1'b1 : phase_q;
            default:     ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_rgb_status_sequencer.sv
module tb_rgb_status_sequencer;

    localparam int DEB = 4;
    localparam int BH  = 3;
    localparam int CW  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       power;
    logic       batery_status;
    logic       allSensores;
    logic       charger;
    logic       out_r, out_g, out_b;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] got, want;

    // Behavioural model: debounced power, state number, cycles spent in the
    // current state (blink phase derived from it), and the latched battery bit.
    int m_state;
    int m_age;
    int m_run;
    bit m_pwr;
    bit m_bat;

    rgb_status_sequencer #(
        .DEB_CYCLES (DEB),
        .BLINK_HALF (BH),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .power         (power),
        .batery_status (batery_status),
        .allSensores   (allSensores),
        .charger       (charger),
        .out_r         (out_r),
        .out_g         (out_g),
        .out_b         (out_b),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Expected {r,g,b,state} from the model.
    function automatic logic [5:0] exp_vec();
        logic lit;
        logic r, g, b;
        lit = ((m_age / BH) % 2) == 0;
        r = 1'b0; g = 1'b0; b = 1'b0;
        case (m_state)
            1: g = 1'b1;
            2: r = lit;
            3: r = 1'b1;
            4: b = m_bat ? 1'b1 : lit;
            default: ;
        endcase
        return {r, g, b, 3'(m_state)};
    endfunction

    task automatic model_step();
        int ns;
        if (reset) begin
            m_state = 0; m_pwr = 0; m_run = 0; m_age = 0; m_bat = 0;
        end else begin
            if (charger)             ns = 4;
            else if (!m_pwr)         ns = 0;
            else if (!batery_status) ns = 3;
            else if (allSensores)    ns = 2;
            else                     ns = 1;
            if (power != m_pwr) begin
                m_run++;
                if (m_run == DEB) begin
                    m_pwr = power;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_age   = (ns != m_state) ? 0 : m_age + 1;
            m_state = ns;
            m_bat   = batery_status;
        end
    endtask

    // One clock: model follows the edge, outputs are observed at the negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        got  = {out_r, out_g, out_b, state};
        want = exp_vec();
    endtask

    task automatic test_reset();
        power = 1; batery_status = 1; allSensores = 1; charger = 1; reset = 1;
        tick(); tick();
        n_checks++;
        if (got !== 6'b000_000) begin
            n_fail++; $display("FAIL reset_hold: got rgb/state %b expected %b", got, 6'b000_000);
        end
        n_checks++;
        if (got !== want) begin
            n_fail++; $display("FAIL reset_model: got %b expected %b", got, want);
        end
        reset = 0;
        tick();
        n_checks++;
        if (state !== 3'd4 || got !== want) begin
            n_fail++; $display("FAIL reset_charger: got state %0d rgb/state %b expected 4 / %b", state, got, want);
        end
    endtask

    task automatic test_debounce();
        reset = 1; charger = 0; power = 0; batery_status = 1; allSensores = 0;
        tick();
        reset = 0;
        tick(); tick();
        power = 1;
        tick(); tick(); tick();
        n_checks++;
        if (dut.pwr_db_q !== 1'b0) begin
            n_fail++; $display("FAIL deb_edge3: got pwr_db %b expected 0", dut.pwr_db_q);
        end
        tick();
        n_checks++;
        if (dut.pwr_db_q !== 1'b1 || state !== 3'd0) begin
            n_fail++; $display("FAIL deb_edge4: got pwr_db %b state %0d expected 1 / 0", dut.pwr_db_q, state);
        end
        tick();
        n_checks++;
        if (state !== 3'd1 || out_g !== 1'b1 || got !== want) begin
            n_fail++; $display("FAIL deb_edge5: got %b expected %b (RUN)", got, want);
        end
        // Back to off, then a too-short pulse must be ignored.
        power = 0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (state !== 3'd0 || got !== want) begin
            n_fail++; $display("FAIL deb_off: got %b expected %b", got, want);
        end
        power = 1;
        tick(); tick(); tick();
        power = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd0 || got !== want) begin
                n_fail++; $display("FAIL deb_glitch[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_blocked_blink();
        logic [8:0] pat;
        pat = 9'b111_000_111;
        power = 1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++; $display("FAIL blink_run: got state %0d expected 1", state);
        end
        allSensores = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd2 || out_r !== pat[8-i] || got !== want) begin
                n_fail++; $display("FAIL blink_r[%0d]: got %b expected r=%b model %b", i, got, pat[8-i], want);
            end
        end
        allSensores = 0;
        tick();
        n_checks++;
        if (state !== 3'd1 || got !== want) begin
            n_fail++; $display("FAIL blink_exit: got %b expected %b", got, want);
        end
    endtask

    task automatic test_priority();
        logic [5:0] bpat;
        bpat = 6'b111_000;
        batery_status = 0; allSensores = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd3 || out_r !== 1'b1 || got !== want) begin
                n_fail++; $display("FAIL prio_lowbat[%0d]: got %b expected %b", i, got, want);
            end
        end
        charger = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd4 || out_b !== bpat[5-i] || got !== want) begin
                n_fail++; $display("FAIL prio_charge[%0d]: got %b expected b=%b model %b", i, got, bpat[5-i], want);
            end
        end
    endtask

    task automatic test_charging_complete();
        batery_status = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (state !== 3'd4 || out_b !== 1'b1 || got !== want) begin
                n_fail++; $display("FAIL charged[%0d]: got %b expected b=1 model %b", i, got, want);
            end
        end
        allSensores = 0; charger = 0;
        tick();
        n_checks++;
        if (state !== 3'd1 || got !== want) begin
            n_fail++; $display("FAIL undock: got %b expected %b", got, want);
        end
    endtask

    task automatic test_reset_mid_blink();
        allSensores = 1;
        tick(); tick(); tick();
        n_checks++;
        if (state !== 3'd2 || dut.blink_cnt_q !== 4'd2) begin
            n_fail++; $display("FAIL midblink_setup: got state %0d cnt %0d expected 2 / 2", state, dut.blink_cnt_q);
        end
        reset = 1;
        tick();
        n_checks++;
        if (got !== 6'b000_000 || dut.blink_cnt_q !== 4'd0 || dut.deb_cnt_q !== 4'd0 || dut.phase_q !== 1'b1) begin
            n_fail++; $display("FAIL midblink_reset: got %b cnt %0d deb %0d phase %b expected 000000 0 0 1",
                               got, dut.blink_cnt_q, dut.deb_cnt_q, dut.phase_q);
        end
        reset = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7, 0) == 0)   power         = ~power;
            if ($urandom_range(9, 0) == 0)   batery_status = ~batery_status;
            if ($urandom_range(5, 0) == 0)   allSensores   = ~allSensores;
            if ($urandom_range(19, 0) == 0)  charger       = ~charger;
            reset = ($urandom_range(149, 0) == 0);
            tick();
            n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL random[%0d]: got %b expected %b", i, got, want);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; power = 0; batery_status = 0; allSensores = 0; charger = 0;
        m_state = 0; m_pwr = 0; m_run = 0; m_age = 0; m_bat = 0;
        @(negedge clk);
        test_reset();
        test_debounce();
        test_blocked_blink();
        test_priority();
        test_charging_complete();
        test_reset_mid_blink();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
